// File: rtl/mealy_fsm_pkg.sv
// Shared types, reset table and helpers for the table-driven Mealy sequencer.
// The reset table only applies at the default widths (2-bit state, 1-bit input, 3-bit output).
package mealy_fsm_pkg;

  localparam int DEF_NSTATE_W = 2;
  localparam int DEF_IN_W     = 1;
  localparam int DEF_OUT_W    = 3;
  localparam int DEF_DEPTH    = 8;

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_C = 2'd2,
    S_D = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] next_state;
    logic [2:0] out;
  } entry_t;

  // Indexed by {state,in}
  localparam entry_t DEFAULT_TABLE [DEF_DEPTH] = '{
    '{S_B, 3'b111},
    '{S_C, 3'b101},
    '{S_D, 3'b001},
    '{S_A, 3'b011},
    '{S_B, 3'b000},
    '{S_D, 3'b100},
    '{S_D, 3'b110},
    '{S_D, 3'b110}
  };

  function automatic int unsigned idx(input int unsigned st, input int unsigned sym,
                                      input int unsigned in_w);
    return (st << in_w) | sym;
  endfunction

endpackage

// File: rtl/mealy_fsm_table_mem.sv
// Flop-based transition/output table: async reset to the power-on contents,
// one write port and one combinational read port (reads see pre-write contents).
module mealy_fsm_table_mem
  import mealy_fsm_pkg::*;
#(
  parameter int NSTATE_W    = 2,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 3,
  parameter int RESET_STATE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_we,
  input  logic [NSTATE_W+IN_W-1:0]   i_waddr,
  input  logic [NSTATE_W+OUT_W-1:0]  i_wdata,
  input  logic [NSTATE_W+IN_W-1:0]   i_raddr,
  output logic [NSTATE_W+OUT_W-1:0]  o_rdata
);

  localparam int AW    = NSTATE_W + IN_W;
  localparam int ENT_W = NSTATE_W + OUT_W;
  localparam int DEPTH = 2 ** AW;
  localparam bit USE_DEF = (NSTATE_W == DEF_NSTATE_W) && (IN_W == DEF_IN_W) &&
                           (OUT_W == DEF_OUT_W);

  logic [ENT_W-1:0] w_init  [DEPTH];
  logic [ENT_W-1:0] r_table [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_init
    if (USE_DEF) begin : g_def
      assign w_init[g] = DEFAULT_TABLE[g];
    end else begin : g_blank
      assign w_init[g] = {NSTATE_W'(RESET_STATE), {OUT_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= w_init[i];
    end else if (i_we) begin
      r_table[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_table[i_raddr];

endmodule

// File: rtl/mealy_fsm_table.sv
// Table-driven Mealy sequencer: state register, optional registered output,
// saturating step counter and absorbing-state (stuck) detection.
module mealy_fsm_table
  import mealy_fsm_pkg::*;
#(
  parameter int NSTATE_W    = 2,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 3,
  parameter int RESET_STATE = 0,
  parameter int REG_OUT     = 0,
  parameter int HOLD_LIMIT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic [IN_W-1:0]            in,
  output logic [OUT_W-1:0]           out,
  output logic                       out_valid,
  output logic [NSTATE_W-1:0]        state,
  input  logic                       cfg_we,
  input  logic [NSTATE_W+IN_W-1:0]   cfg_addr,
  input  logic [NSTATE_W+OUT_W-1:0]  cfg_data,
  output logic                       stuck,
  output logic [CNT_W-1:0]           step_cnt
);

  localparam int AW    = NSTATE_W + IN_W;
  localparam int ENT_W = NSTATE_W + OUT_W;
  localparam logic [NSTATE_W-1:0] RST_ST    = NSTATE_W'(RESET_STATE);
  localparam logic [7:0]          HOLD_LIM8 = 8'(HOLD_LIMIT);

  logic [NSTATE_W-1:0] r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_step_cnt, w_cnt_nxt;
  logic [7:0]          r_loop_cnt, w_loop_nxt;
  logic                r_stuck, w_stuck_nxt;

  logic [AW-1:0]       w_raddr;
  logic [ENT_W-1:0]    w_entry;
  logic [NSTATE_W-1:0] w_next;
  logic [OUT_W-1:0]    w_eout;
  logic                w_step;

  assign w_raddr = AW'(idx(32'(r_state), 32'(in), IN_W));
  assign w_next  = w_entry[ENT_W-1:OUT_W];
  assign w_eout  = w_entry[OUT_W-1:0];
  assign w_step  = en & ~clr;

  mealy_fsm_table_mem #(
    .NSTATE_W    (NSTATE_W),
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .RESET_STATE (RESET_STATE)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (w_raddr),
    .o_rdata (w_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RST_ST;
      r_step_cnt <= '0;
      r_loop_cnt <= '0;
      r_stuck    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_cnt_nxt;
      r_loop_cnt <= w_loop_nxt;
      r_stuck    <= w_stuck_nxt;
    end
  end

  // clr outranks a step; stuck is derived from the post-step self-loop count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_step_cnt;
    w_loop_nxt  = r_loop_cnt;
    w_stuck_nxt = r_stuck;
    if (clr) begin
      w_state_nxt = RST_ST;
      w_cnt_nxt   = '0;
      w_loop_nxt  = '0;
      w_stuck_nxt = 1'b0;
    end else if (en) begin
      w_state_nxt = w_next;
      if (!(&r_step_cnt)) w_cnt_nxt = r_step_cnt + CNT_W'(1);
      if (w_next == r_state) begin
        if (r_loop_cnt != 8'hFF) w_loop_nxt = r_loop_cnt + 8'd1;
      end else begin
        w_loop_nxt = '0;
      end
      w_stuck_nxt = (w_loop_nxt >= HOLD_LIM8);
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [OUT_W-1:0] r_out;
    logic             r_out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end else if (clr) begin
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end else if (w_step) begin
        r_out       <= w_eout;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
  end else begin : g_comb_out
    assign out       = w_eout;
    assign out_valid = w_step;
  end

  assign state    = r_state;
  assign stuck    = r_stuck;
  assign step_cnt = r_step_cnt;

endmodule
